rtc_irq_ctrl: RTL and testbench

//  Consumer of the RTC/PRAM block's onesecond_irq/qtrsecond_irq outputs. Latches timer, scanline and VBL

---
 rtl/iigs_irq_pkg.sv | 35 +++
 rtl/irq_edge_latch.sv | 41 ++++
 rtl/rtc_irq_ctrl.sv | 122 ++++++++++++
 tb/tb_rtc_irq_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/iigs_irq_pkg.sv
// rtl/iigs_irq_pkg.sv - IIGS interrupt soft-switch addresses and register bit positions
package iigs_irq_pkg;

  localparam logic [7:0] ADDR_C023 = 8'h23;
  localparam logic [7:0] ADDR_C032 = 8'h32;
  localparam logic [7:0] ADDR_C041 = 8'h41;
  localparam logic [7:0] ADDR_C046 = 8'h46;
  localparam logic [7:0] ADDR_C047 = 8'h47;

  // C023 VGCINT
  localparam int C023_IRQ     = 7;
  localparam int C023_ST_1S   = 6;
  localparam int C023_ST_SCAN = 5;
  localparam int C023_EN_1S   = 2;
  localparam int C023_EN_SCAN = 1;

  // C032 SCANINT: a zero in these bits clears the matching status
  localparam int C032_KEEP_1S   = 6;
  localparam int C032_KEEP_SCAN = 5;

  // C041 INTEN
  localparam int C041_EN_QTR      = 4;
  localparam int C041_EN_VBL      = 3;
  localparam int C041_INTEN_LO_HI = 2;

  // C046 INTFLAG
  localparam int C046_ST_QTR = 4;
  localparam int C046_ST_VBL = 3;

  function automatic logic is_irq_addr(input logic [7:0] a);
    return (a == ADDR_C023) || (a == ADDR_C032) || (a == ADDR_C041) ||
           (a == ADDR_C046) || (a == ADDR_C047);
  endfunction

endpackage

// File: rtl/irq_edge_latch.sv
// rtl/irq_edge_latch.sv - per-source rising-edge detect and set-over-clear status latch
module irq_edge_latch #(
  parameter int SYNC_SRC = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic en,
  input  logic clr,
  output logic status
);

  logic src_s;
  logic src_d;

  generate
    if (SYNC_SRC != 0) begin : g_sync
      logic src_r;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) src_r <= 1'b0;
        else       src_r <= src;
      end
      assign src_s = src_r;
    end else begin : g_nosync
      assign src_s = src;
    end
  endgenerate

  // en is the registered enable, so a same-clk enable write still sees the old value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_d  <= 1'b0;
      status <= 1'b0;
    end else begin
      src_d <= src_s;
      if (src_s && !src_d && en) status <= 1'b1;
      else if (clr)              status <= 1'b0;
    end
  end

endmodule

// File: rtl/rtc_irq_ctrl.sv
// rtl/rtc_irq_ctrl.sv - IIGS timer/scanline/VBL interrupt status regs and CPU irq; VBL path under VBL_IRQ_EN
module rtc_irq_ctrl
  import iigs_irq_pkg::*;
#(
  parameter int SYNC_SRC = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cen,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  input  logic       rw,
  input  logic       strobe,
  input  logic       onesec_in,
  input  logic       qtrsec_in,
  input  logic       scan_in,
  input  logic       vbl_in,
  output logic       sel,
  output logic [7:0] dout,
  output logic       irq
);

  logic       acc, wr, rd;
  logic       en_1s, en_scan, en_qtr, en_vbl;
  logic [2:0] inten_lo;
  logic       st_1s, st_scan, st_qtr, st_vbl;
  logic       clr_1s, clr_scan, clr_qv;
  logic [7:0] rd_data;

  assign sel = is_irq_addr(addr);
  assign acc = strobe && cen;
  assign wr  = acc && !rw;
  assign rd  = acc && rw;

  assign clr_1s   = wr && (addr == ADDR_C032) && !din[C032_KEEP_1S];
  assign clr_scan = wr && (addr == ADDR_C032) && !din[C032_KEEP_SCAN];
  assign clr_qv   = acc && (addr == ADDR_C047);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_1s    <= 1'b0;
      en_scan  <= 1'b0;
      en_qtr   <= 1'b0;
      inten_lo <= 3'b000;
    end else if (wr) begin
      if (addr == ADDR_C023) begin
        en_1s   <= din[C023_EN_1S];
        en_scan <= din[C023_EN_SCAN];
      end
      if (addr == ADDR_C041) begin
        en_qtr   <= din[C041_EN_QTR];
        inten_lo <= din[C041_INTEN_LO_HI:0];
      end
    end
  end

  irq_edge_latch #(.SYNC_SRC(SYNC_SRC)) u_lat_1s (
    .clk(clk), .reset(reset), .src(onesec_in), .en(en_1s), .clr(clr_1s), .status(st_1s)
  );

  irq_edge_latch #(.SYNC_SRC(SYNC_SRC)) u_lat_scan (
    .clk(clk), .reset(reset), .src(scan_in), .en(en_scan), .clr(clr_scan), .status(st_scan)
  );

  irq_edge_latch #(.SYNC_SRC(SYNC_SRC)) u_lat_qtr (
    .clk(clk), .reset(reset), .src(qtrsec_in), .en(en_qtr), .clr(clr_qv), .status(st_qtr)
  );

`ifdef VBL_IRQ_EN
  logic unused_din;
  assign unused_din = din[7];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             en_vbl <= 1'b0;
    else if (wr && (addr == ADDR_C041))    en_vbl <= din[C041_EN_VBL];
  end

  irq_edge_latch #(.SYNC_SRC(SYNC_SRC)) u_lat_vbl (
    .clk(clk), .reset(reset), .src(vbl_in), .en(en_vbl), .clr(clr_qv), .status(st_vbl)
  );
`else
  logic unused_in;
  assign unused_in = ^{din[7], din[3], vbl_in};
  assign en_vbl    = 1'b0;
  assign st_vbl    = 1'b0;
`endif

  always_comb begin
    rd_data = 8'h00;
    case (addr)
      ADDR_C023: begin
        rd_data[C023_IRQ]     = (st_1s && en_1s) || (st_scan && en_scan);
        rd_data[C023_ST_1S]   = st_1s;
        rd_data[C023_ST_SCAN] = st_scan;
        rd_data[C023_EN_1S]   = en_1s;
        rd_data[C023_EN_SCAN] = en_scan;
      end
      ADDR_C041: begin
        rd_data[C041_EN_QTR]            = en_qtr;
        rd_data[C041_EN_VBL]            = en_vbl;
        rd_data[C041_INTEN_LO_HI:0]     = inten_lo;
      end
      ADDR_C046: begin
        rd_data[C046_ST_QTR] = st_qtr;
        rd_data[C046_ST_VBL] = st_vbl;
      end
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout <= 8'h00;
      irq  <= 1'b0;
    end else begin
      if (rd && sel) dout <= rd_data;
      irq <= (st_1s && en_1s) || (st_scan && en_scan) ||
             (st_qtr && en_qtr) || (st_vbl && en_vbl);
    end
  end

endmodule

// File: tb/tb_rtc_irq_ctrl.sv
// tb/tb_rtc_irq_ctrl.sv - directed self-checking bench for rtc_irq_ctrl
module tb_rtc_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cen;
  logic [7:0] addr;
  logic [7:0] din;
  logic       rw;
  logic       strobe;
  logic       onesec_in, qtrsec_in, scan_in, vbl_in;
  logic       sel;
  logic [7:0] dout;
  logic       irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] rdv;

  rtc_irq_ctrl dut (
    .clk(clk), .reset(reset), .cen(cen), .addr(addr), .din(din), .rw(rw),
    .strobe(strobe), .onesec_in(onesec_in), .qtrsec_in(qtrsec_in),
    .scan_in(scan_in), .vbl_in(vbl_in), .sel(sel), .dout(dout), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; din = d; rw = 1'b0; strobe = 1'b1;
    tick();
    strobe = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [7:0] d);
    addr = a; rw = 1'b1; strobe = 1'b1;
    tick();
    strobe = 1'b0;
    d = dout;
  endtask

  initial begin
    reset = 1'b1; cen = 1'b1; addr = 8'h00; din = 8'h00; rw = 1'b1; strobe = 1'b0;
    onesec_in = 0; qtrsec_in = 0; scan_in = 0; vbl_in = 0;
    repeat (3) tick();
    check("rst_irq", {7'b0, irq}, 8'h00);
    check("rst_dout", dout, 8'h00);
    reset = 1'b0;
    tick();

    addr = 8'h23; #1;
    check("sel_23", {7'b0, sel}, 8'h01);
    addr = 8'h24; #1;
    check("sel_24", {7'b0, sel}, 8'h00);

    cen = 1'b0;
    bus_wr(8'h23, 8'h04);
    cen = 1'b1;
    bus_rd(8'h23, rdv);
    check("cen_gate", rdv, 8'h00);

    bus_wr(8'h23, 8'h04);
    onesec_in = 1'b1;
    tick();
    onesec_in = 1'b0;
    check("1s_irq_lat1", {7'b0, irq}, 8'h00);
    tick();
    check("1s_irq_lat2", {7'b0, irq}, 8'h01);
    bus_rd(8'h23, rdv);
    check("c023_c4", rdv, 8'hC4);

    bus_wr(8'h23, 8'h00);
    tick();
    check("mask_irq", {7'b0, irq}, 8'h00);
    bus_rd(8'h23, rdv);
    check("mask_keep_st", rdv, 8'h40);
    bus_wr(8'h23, 8'h04);
    tick();
    check("reenable_irq", {7'b0, irq}, 8'h01);

    bus_wr(8'h32, 8'hBF);
    tick();
    check("c032_clr_irq", {7'b0, irq}, 8'h00);
    bus_rd(8'h23, rdv);
    check("c023_04", rdv, 8'h04);
    bus_rd(8'h30, rdv);
    check("nonsel_hold", rdv, 8'h04);

    bus_wr(8'h41, 8'h10);
    bus_rd(8'h41, rdv);
    check("c041_10", rdv, 8'h10);
    qtrsec_in = 1'b1;
    repeat (3) tick();
    bus_rd(8'h46, rdv);
    check("c046_qtr", rdv, 8'h10);
    check("qtr_irq", {7'b0, irq}, 8'h01);
    bus_rd(8'h47, rdv);
    check("c047_rd", rdv, 8'h00);
    repeat (95) tick();
    bus_rd(8'h46, rdv);
    check("qtr_level_once", rdv, 8'h00);
    check("qtr_irq_clr", {7'b0, irq}, 8'h00);
    qtrsec_in = 1'b0;
    tick();
    qtrsec_in = 1'b1;
    repeat (2) tick();
    bus_rd(8'h46, rdv);
    check("qtr_reset", rdv, 8'h10);
    qtrsec_in = 1'b0;
    bus_rd(8'h47, rdv);
    bus_wr(8'h41, 8'h00);

    bus_wr(8'h23, 8'h00);
    scan_in = 1'b1;
    tick();
    scan_in = 1'b0;
    tick();
    bus_rd(8'h23, rdv);
    check("scan_lost", rdv, 8'h00);
    bus_wr(8'h23, 8'h02);
    repeat (2) tick();
    check("scan_lost_irq", {7'b0, irq}, 8'h00);
    bus_rd(8'h23, rdv);
    check("c023_02", rdv, 8'h02);

    addr = 8'h32; din = 8'hDF; rw = 1'b0; strobe = 1'b1; scan_in = 1'b1;
    tick();
    strobe = 1'b0; scan_in = 1'b0;
    tick();
    check("simul_irq", {7'b0, irq}, 8'h01);
    bus_rd(8'h23, rdv);
    check("simul_c023", rdv, 8'hA2);

    bus_wr(8'h23, 8'h00);
    bus_wr(8'h32, 8'h00);
    bus_rd(8'h47, rdv);
    bus_wr(8'h41, 8'h08);
    repeat (2) tick();
    check("vbl_pre_irq", {7'b0, irq}, 8'h00);
    vbl_in = 1'b1;
    tick();
    vbl_in = 1'b0;
    repeat (2) tick();
    bus_rd(8'h46, rdv);
`ifdef VBL_IRQ_EN
    check("vbl_c046", rdv, 8'h08);
    check("vbl_irq", {7'b0, irq}, 8'h01);
    bus_rd(8'h41, rdv);
    check("vbl_c041", rdv, 8'h08);
`else
    check("vbl_c046", rdv, 8'h00);
    check("vbl_irq", {7'b0, irq}, 8'h00);
    bus_rd(8'h41, rdv);
    check("vbl_c041", rdv, 8'h00);
`endif

    bus_wr(8'h23, 8'h04);
    onesec_in = 1'b1;
    tick();
    onesec_in = 1'b0;
    tick();
    check("pre_rst_irq", {7'b0, irq}, 8'h01);
    #2 reset = 1'b1;
    #1;
    check("midrst_irq", {7'b0, irq}, 8'h00);
    check("midrst_dout", dout, 8'h00);
    @(posedge clk);
    #1 reset = 1'b0;
    bus_rd(8'h23, rdv);
    check("rst_c023", rdv, 8'h00);
    bus_rd(8'h41, rdv);
    check("rst_c041", rdv, 8'h00);
    bus_rd(8'h46, rdv);
    check("rst_c046", rdv, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
